// File: rtl/mem_addr_select.sv
// mem_addr_select: picks one of NUM_SRC address sources, presents it to memory and waits
// for mem_ready with a bounded timeout. Define MEM_ADDR_SELECT_ALIGN_CHK_EN to enable alignment checks.
module mem_addr_select #(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                sel,
  input  logic [NUM_SRC*DATA_W-1:0] src,
  input  logic [1:0]                size,
  input  logic                      req,
  input  logic                      mem_ready,
  output logic [DATA_W-1:0]         addr,
  output logic                      addr_valid,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [1:0]                err_code
);

  localparam int         SEL_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;
  logic [DATA_W-1:0] src_sel_s;
  logic              sel_bad_s;
  logic              misalign_s;

`ifdef MEM_ADDR_SELECT_ALIGN_CHK_EN
  function automatic logic misaligned_f(input logic [1:0] size_v, input logic [1:0] lsb_v);
    logic bad_v;
    case (size_v)
      2'b00:   bad_v = 1'b0;
      2'b01:   bad_v = lsb_v[0];
      2'b10:   bad_v = (lsb_v != 2'b00);
      default: bad_v = 1'b1;
    endcase
    return bad_v;
  endfunction

  assign misalign_s = misaligned_f(size, src_sel_s[1:0]);
`else
  logic unused_size_s;
  assign unused_size_s = ^size;
  assign misalign_s    = 1'b0;
`endif

  // The full 4-bit select is range-checked; only the low SEL_W bits steer the mux.
  assign sel_bad_s = ({28'd0, sel} >= 32'(NUM_SRC));

  // AND-OR source mux: defined for every select value, no priority chain
  always_comb begin
    src_sel_s = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      src_sel_s = src_sel_s
                | (src[k*DATA_W +: DATA_W] & {DATA_W{sel[SEL_W-1:0] == SEL_W'(k)}});
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req && !sel_bad_s && !misalign_s) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (mem_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // cnt_q == 1 is the last WAIT cycle: the counter reaches 0 at this edge
        if (mem_ready || (cnt_q <= 8'd1)) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM output and datapath next values
  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    code_d = code_q;
    case (state_q)
      S_IDLE: begin
        if (req && sel_bad_s) begin
          err_d  = 1'b1;
          code_d = 2'b01;
        end else if (req) begin
          addr_d = src_sel_s;
          if (misalign_s) begin
            err_d  = 1'b1;
            code_d = 2'b10;
          end else begin
            err_d  = 1'b0;
          end
        end else begin
          addr_d = addr_q;
        end
      end
      S_ISSUE: begin
        if (mem_ready) begin
          done_d = 1'b1;
          cnt_d  = 8'd0;
        end else begin
          cnt_d  = TIMEOUT_C;
        end
      end
      S_WAIT: begin
        if (mem_ready) begin
          done_d = 1'b1;
          cnt_d  = 8'd0;
        end else if (cnt_q <= 8'd1) begin
          err_d  = 1'b1;
          code_d = 2'b11;
          cnt_d  = 8'd0;
        end else begin
          cnt_d  = cnt_q - 8'd1;
        end
      end
      default: begin
        cnt_d = 8'd0;
      end
    endcase
    valid_d = (state_d != S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  // Registered outputs, counter and captured address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      cnt_q   <= 8'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign addr       = addr_q;
  assign addr_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = code_q;

endmodule

// File: tb/tb_mem_addr_select.sv
// Directed bench for mem_addr_select: transaction-level reference model checked every
// negedge, plus hand-computed literal expectations for the key scenarios.
module tb_mem_addr_select;
  localparam int DW = 32;
  localparam int NS = 8;
  localparam int TO = 3;
`ifdef MEM_ADDR_SELECT_ALIGN_CHK_EN
  localparam bit ALIGN_ON = 1'b1;
`else
  localparam bit ALIGN_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       sel;
  logic [NS*DW-1:0] src;
  logic [1:0]       size;
  logic             req;
  logic             mem_ready;
  logic [DW-1:0]    addr;
  logic             addr_valid;
  logic             busy;
  logic             done;
  logic             err;
  logic [1:0]       err_code;

  int n_checks = 0;
  int n_fail   = 0;

  mem_addr_select #(.DATA_W(DW), .NUM_SRC(NS), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .sel(sel), .src(src), .size(size), .req(req),
    .mem_ready(mem_ready), .addr(addr), .addr_valid(addr_valid), .busy(busy),
    .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic model_misaligned(input logic [1:0] sz, input logic [31:0] a);
    return ALIGN_ON && ((sz == 2'b11) || (sz == 2'b01 && (a % 2) != 0) ||
                        (sz == 2'b10 && (a % 4) != 0));
  endfunction

  // Reference model: an access is "in flight" for m_age cycles; it ends on
  // mem_ready, or aborts once TO wait cycles have passed without it.
  logic [31:0] m_addr = 32'd0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_err  = 1'b0;
  logic [1:0]  m_code = 2'b00;
  int          m_age  = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_addr <= 32'd0; m_busy <= 1'b0; m_done <= 1'b0;
      m_err  <= 1'b0;  m_code <= 2'b00; m_age <= 0;
    end else begin
      m_done <= 1'b0;
      m_err  <= 1'b0;
      if (!m_busy) begin
        if (req) begin
          if (int'(sel) >= NS) begin
            m_err <= 1'b1; m_code <= 2'b01;
          end else begin
            m_addr <= src[int'(sel)*DW +: DW];
            if (model_misaligned(size, src[int'(sel)*DW +: DW])) begin
              m_err <= 1'b1; m_code <= 2'b10;
            end else begin
              m_busy <= 1'b1; m_age <= 0;
            end
          end
        end
      end else if (mem_ready) begin
        m_done <= 1'b1; m_busy <= 1'b0;
      end else if (m_age == TO) begin
        m_err <= 1'b1; m_code <= 2'b11; m_busy <= 1'b0;
      end else begin
        m_age <= m_age + 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_addr", addr, m_addr);
    chk("m_addr_valid", 32'(addr_valid), 32'(m_busy));
    chk("m_busy", 32'(busy), 32'(m_busy));
    chk("m_done", 32'(done), 32'(m_done));
    chk("m_err", 32'(err), 32'(m_err));
    chk("m_err_code", 32'(err_code), 32'(m_code));
  end

  initial begin
    reset = 1'b0; sel = 4'd0; size = 2'b00; req = 1'b0; mem_ready = 1'b0;
    for (int k = 0; k < NS; k++) src[k*DW +: DW] = 32'h0000_1000 + 32'(k * 16);
    src[2*DW +: DW] = 32'h0000_0100;
    src[1*DW +: DW] = 32'h0000_0102;
    #1 reset = 1'b1;
    step; step;
    chk("rst_addr", addr, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    reset = 1'b0;

    // basic access, mem_ready in the first WAIT cycle
    sel = 4'd2; size = 2'b10; req = 1'b1;
    step;
    chk("b_addr", addr, 32'h0000_0100);
    chk("b_valid1", 32'(addr_valid), 32'd1);
    chk("b_busy", 32'(busy), 32'd1);
    req = 1'b0;
    step;
    chk("b_valid2", 32'(addr_valid), 32'd1);
    mem_ready = 1'b1;
    step;
    chk("b_done", 32'(done), 32'd1);
    chk("b_valid3", 32'(addr_valid), 32'd0);
    chk("b_busy_end", 32'(busy), 32'd0);
    mem_ready = 1'b0;
    step;
    chk("b_done_once", 32'(done), 32'd0);

    // bad select
    sel = 4'd9; req = 1'b1;
    step;
    chk("bs_err", 32'(err), 32'd1);
    chk("bs_code", 32'(err_code), 32'd1);
    chk("bs_busy", 32'(busy), 32'd0);
    chk("bs_addr", addr, 32'h0000_0100);
    req = 1'b0;
    step;
    chk("bs_err_pulse", 32'(err), 32'd0);
    chk("bs_code_hold", 32'(err_code), 32'd1);

    // alignment: word access at 0x102, then half access at 0x102
    sel = 4'd1; size = 2'b10; req = 1'b1;
    step;
`ifdef MEM_ADDR_SELECT_ALIGN_CHK_EN
    chk("al_err", 32'(err), 32'd1);
    chk("al_code", 32'(err_code), 32'd2);
    chk("al_busy", 32'(busy), 32'd0);
`else
    chk("al_issued", 32'(busy), 32'd1);
`endif
    req = 1'b0; mem_ready = 1'b1;
    step;
    mem_ready = 1'b0;
    step;
    size = 2'b01; req = 1'b1;
    step;
    chk("al_half_busy", 32'(busy), 32'd1);
    chk("al_half_addr", addr, 32'h0000_0102);
    req = 1'b0; mem_ready = 1'b1;
    step;
    chk("issue_done", 32'(done), 32'd1);
    mem_ready = 1'b0;

    // timeout: err exactly 5 cycles after the request cycle
    sel = 4'd3; size = 2'b00; req = 1'b1;
    step; req = 1'b0;
    step; step; step;
    chk("to_wait_busy", 32'(busy), 32'd1);
    chk("to_no_err_yet", 32'(err), 32'd0);
    step;
    chk("to_err", 32'(err), 32'd1);
    chk("to_code", 32'(err_code), 32'd3);
    chk("to_idle", 32'(busy), 32'd0);
    step;
    chk("to_code_hold", 32'(err_code), 32'd3);

    // ready on the last WAIT cycle wins over timeout
    req = 1'b1;
    step; req = 1'b0;
    step; step; step;
    mem_ready = 1'b1;
    step;
    chk("last_done", 32'(done), 32'd1);
    chk("last_no_err", 32'(err), 32'd0);
    mem_ready = 1'b0;
    step;

    // every select value, memory always ready
    for (int s = 0; s < 16; s++) begin
      sel = 4'(s); mem_ready = 1'b1; req = 1'b1;
      step; req = 1'b0;
      step; step;
    end
    mem_ready = 1'b0;

    // changes while busy are ignored; reset in WAIT aborts at once
    sel = 4'd4; req = 1'b1;
    step; req = 1'b0;
    chk("hold_addr1", addr, 32'h0000_1040);
    step;
    src[4*DW +: DW] = 32'hDEAD_BEE0; sel = 4'd5; req = 1'b1;
    step;
    chk("hold_addr2", addr, 32'h0000_1040);
    chk("hold_busy", 32'(busy), 32'd1);
    req = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("ar_addr", addr, 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_valid", 32'(addr_valid), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    chk("ar_err", 32'(err), 32'd0);
    chk("ar_code", 32'(err_code), 32'd0);
    step; step;

    // first req right after reset, held high across a completion
    reset = 1'b0; sel = 4'd0; req = 1'b1;
    step;
    chk("pr_busy", 32'(busy), 32'd1);
    chk("pr_addr", addr, 32'h0000_1000);
    mem_ready = 1'b1;
    step;
    chk("pr_done", 32'(done), 32'd1);
    chk("pr_idle", 32'(busy), 32'd0);
    step;
    chk("pr_restart", 32'(busy), 32'd1);
    req = 1'b0;
    step;
    chk("pr_done2", 32'(done), 32'd1);
    mem_ready = 1'b0;
    step; step;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
